// File: rtl/sap1_bus_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap1_bus_datapath_pkg
// Description : Shared bus-select codes and default geometry for the SAP-1
//               bus datapath. Code 0 (and any unlisted code) drives the bus
//               to zero.
// Revision    : 1.0  initial release
// ============================================================================
package sap1_bus_datapath_pkg;

   typedef enum logic [2:0] {
      BUS_SEL_NONE = 3'd0,
      BUS_SEL_CTRL = 3'd1,
      BUS_SEL_PC   = 3'd2,
      BUS_SEL_MEM  = 3'd3,
      BUS_SEL_ALU  = 3'd4,
      BUS_SEL_MAC  = 3'd5
   } bus_sel_e;

   localparam int unsigned DEF_BUS_LATENCY = 3;
   localparam int unsigned DEF_ADDR_WIDTH  = 8;
   localparam int unsigned DEF_DATA_WIDTH  = 16;

endpackage : sap1_bus_datapath_pkg
`default_nettype wire

// File: rtl/sap1_bus_datapath_ram.sv
`default_nettype none
// ============================================================================
// Module      : sap1_bus_datapath_ram
// Description : Synchronous, read-first single-port data RAM. The read
//               register samples mem[addr] every cycle; a write in the same
//               cycle lands in the array while the read returns the old word.
//               The array is never cleared; only the read register resets.
// Ports       : clk, reset      - clock, sync active-high reset (rdata only)
//               addr            - word address (MAR)
//               wen, wdata      - write strobe and write data (MDR)
//               rdata           - registered read data
// Revision    : 1.0  initial release
// ============================================================================
module sap1_bus_datapath_ram
   import sap1_bus_datapath_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   always_comb begin
      rdata_d = mem_q[addr];
   end

   // Array storage deliberately has no reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem_q[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule : sap1_bus_datapath_ram
`default_nettype wire

// File: rtl/sap1_bus_datapath.sv
`default_nettype none
// ============================================================================
// Module      : sap1_bus_datapath
// Description : Responder end of the SAP-1 shared bus. A combinational source
//               mux feeds a fixed-depth bus pipeline; every sink (PC, MAR,
//               MDR, IR, OUT) samples the pipeline output, never the raw mux.
//               The controller counts BUS_LATENCY cycles itself: there is no
//               handshake back.
// Ports       : clk, reset                 - clock, sync active-high reset
//               bus_sel_in                 - bus source select code
//               ctrl_data/alu_result/mac_result - bus source data
//               pc_reset/pc_load/pc_increment  - PC controls (that priority)
//               addr_reg_en/data_reg_en    - MAR / MDR capture
//               mem_wen                    - RAM[MAR] <= MDR
//               inst_reg_en/out_reg_en     - IR / OUT capture
//               bus_data                   - pipelined bus value
//               inst_reg, out_reg, pc      - register outputs
// Revision    : 1.0  initial release
// ============================================================================
module sap1_bus_datapath
   import sap1_bus_datapath_pkg::*;
#(
   parameter int unsigned BUS_LATENCY = DEF_BUS_LATENCY,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            bus_sel_in,
   input  logic [DATA_WIDTH-1:0] ctrl_data,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic [DATA_WIDTH-1:0] mac_result,
   input  logic                  pc_reset,
   input  logic                  pc_load,
   input  logic                  pc_increment,
   input  logic                  addr_reg_en,
   input  logic                  data_reg_en,
   input  logic                  mem_wen,
   input  logic                  inst_reg_en,
   input  logic                  out_reg_en,
   output logic [DATA_WIDTH-1:0] bus_data,
   output logic [DATA_WIDTH-1:0] inst_reg,
   output logic [DATA_WIDTH-1:0] out_reg,
   output logic [ADDR_WIDTH-1:0] pc
);

   // Zero-extension of the PC onto the bus assumes DATA_WIDTH > ADDR_WIDTH.
   localparam int unsigned PAD_WIDTH = DATA_WIDTH - ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] bus_mux;
   logic [DATA_WIDTH-1:0] pipe_q [BUS_LATENCY];
   logic [DATA_WIDTH-1:0] pipe_d [BUS_LATENCY];

   logic [ADDR_WIDTH-1:0] pc_q,  pc_d;
   logic [ADDR_WIDTH-1:0] mar_q, mar_d;
   logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
   logic [DATA_WIDTH-1:0] ir_q,  ir_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // ---------------------------------------------------------------------
   // Bus source mux; unlisted codes (including 0) drive zero.
   // ---------------------------------------------------------------------
   always_comb begin
      bus_mux = '0;
      case (bus_sel_in)
         BUS_SEL_CTRL: bus_mux = ctrl_data;
         BUS_SEL_PC:   bus_mux = {{PAD_WIDTH{1'b0}}, pc_q};
         BUS_SEL_MEM:  bus_mux = mem_rdata;
         BUS_SEL_ALU:  bus_mux = alu_result;
         BUS_SEL_MAC:  bus_mux = mac_result;
         default:      bus_mux = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Bus pipeline: a source selected at one edge reaches bus_data after
   // BUS_LATENCY edges.
   // ---------------------------------------------------------------------
   always_comb begin
      pipe_d[0] = bus_mux;
      for (int k = 1; k < BUS_LATENCY; k++) begin
         pipe_d[k] = pipe_q[k-1];
      end
   end

   assign bus_data = pipe_q[BUS_LATENCY-1];

   // ---------------------------------------------------------------------
   // Sink registers; all capture from bus_data (the pipeline output).
   // ---------------------------------------------------------------------
   always_comb begin
      pc_d  = pc_q;
      mar_d = mar_q;
      mdr_d = mdr_q;
      ir_d  = ir_q;
      out_d = out_q;

      if (pc_reset) begin
         pc_d = '0;
      end else if (pc_load) begin
         pc_d = bus_data[ADDR_WIDTH-1:0];
      end else if (pc_increment) begin
         pc_d = pc_q + 1'b1;           // wraps naturally at 2**ADDR_WIDTH
      end

      if (addr_reg_en) mar_d = bus_data[ADDR_WIDTH-1:0];
      if (data_reg_en) mdr_d = bus_data;
      if (inst_reg_en) ir_d  = bus_data;
      if (out_reg_en)  out_d = bus_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < BUS_LATENCY; k++) begin
            pipe_q[k] <= '0;
         end
         pc_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         ir_q  <= '0;
         out_q <= '0;
      end else begin
         pipe_q <= pipe_d;
         pc_q   <= pc_d;
         mar_q  <= mar_d;
         mdr_q  <= mdr_d;
         ir_q   <= ir_d;
         out_q  <= out_d;
      end
   end

   // ---------------------------------------------------------------------
   // Data RAM. It sees the registered MAR/MDR, so a same-cycle MAR or MDR
   // update does not affect the write in that cycle.
   // ---------------------------------------------------------------------
   sap1_bus_datapath_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .addr  (mar_q),
      .wen   (mem_wen),
      .wdata (mdr_q),
      .rdata (mem_rdata)
   );

   assign inst_reg = ir_q;
   assign out_reg  = out_q;
   assign pc       = pc_q;

endmodule : sap1_bus_datapath
`default_nettype wire

// File: tb/tb_sap1_bus_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap1_bus_datapath
// Description : Self-checking bench for sap1_bus_datapath. A behavioural
//               model (delay queue for the bus, plain variables and an array
//               for the registers and RAM) runs alongside the DUT and is
//               compared on every negative clock edge; directed scenarios
//               add literal expectations, then a randomized phase follows.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sap1_bus_datapath;
   import sap1_bus_datapath_pkg::*;

   localparam int L = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  bus_sel_in = 3'd0;
   logic [15:0] ctrl_data = '0, alu_result = '0, mac_result = '0;
   logic        pc_reset = 0, pc_load = 0, pc_increment = 0;
   logic        addr_reg_en = 0, data_reg_en = 0, mem_wen = 0;
   logic        inst_reg_en = 0, out_reg_en = 0;
   logic [15:0] bus_data, inst_reg, out_reg;
   logic [7:0]  pc;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   sap1_bus_datapath #(.BUS_LATENCY(L), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus_sel_in   (bus_sel_in),
      .ctrl_data    (ctrl_data),
      .alu_result   (alu_result),
      .mac_result   (mac_result),
      .pc_reset     (pc_reset),
      .pc_load      (pc_load),
      .pc_increment (pc_increment),
      .addr_reg_en  (addr_reg_en),
      .data_reg_en  (data_reg_en),
      .mem_wen      (mem_wen),
      .inst_reg_en  (inst_reg_en),
      .out_reg_en   (out_reg_en),
      .bus_data     (bus_data),
      .inst_reg     (inst_reg),
      .out_reg      (out_reg),
      .pc           (pc)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   logic [15:0] m_bq[$];          // values in flight on the bus, oldest first
   logic [15:0] m_ram [256];
   logic [7:0]  m_pc = 0, m_mar = 0;
   logic [15:0] m_mdr = 0, m_ir = 0, m_out = 0, m_rdata = 0;
   logic [15:0] m_src, m_bus_now, m_rd;

   initial begin
      for (int i = 0; i < L; i++) m_bq.push_back(16'h0);
      for (int i = 0; i < 256; i++) m_ram[i] = 16'h0;
   end

   always @(posedge clk) begin
      m_bus_now = m_bq[0];
      case (bus_sel_in)
         BUS_SEL_CTRL: m_src = ctrl_data;
         BUS_SEL_PC:   m_src = {8'h00, m_pc};
         BUS_SEL_MEM:  m_src = m_rdata;
         BUS_SEL_ALU:  m_src = alu_result;
         BUS_SEL_MAC:  m_src = mac_result;
         default:      m_src = 16'h0;
      endcase
      // RAM: read-first, write uses the MAR/MDR held before this edge.
      m_rd = m_ram[m_mar];
      if (mem_wen) m_ram[m_mar] = m_mdr;
      if (reset) begin
         m_bq.delete();
         for (int i = 0; i < L; i++) m_bq.push_back(16'h0);
         m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_out = 0; m_rdata = 0;
      end else begin
         m_rdata = m_rd;
         if (pc_reset)          m_pc = 8'h00;
         else if (pc_load)      m_pc = m_bus_now[7:0];
         else if (pc_increment) m_pc = m_pc + 8'd1;
         if (addr_reg_en) m_mar = m_bus_now[7:0];
         if (data_reg_en) m_mdr = m_bus_now;
         if (inst_reg_en) m_ir  = m_bus_now;
         if (out_reg_en)  m_out = m_bus_now;
         m_bq.push_back(m_src);
         void'(m_bq.pop_front());
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("model bus_data", bus_data, m_bq[0]);
         check("model inst_reg", inst_reg, m_ir);
         check("model out_reg",  out_reg,  m_out);
         check("model pc",       {8'h00, pc}, {8'h00, m_pc});
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobes(input logic [7:0] s);
      pc_load      = s[0];
      pc_increment = s[1];
      pc_reset     = s[2];
      addr_reg_en  = s[3];
      data_reg_en  = s[4];
      mem_wen      = s[5];
      inst_reg_en  = s[6];
      out_reg_en   = s[7];
   endtask

   localparam logic [7:0] S_PCLD = 8'h01, S_PCINC = 8'h02, S_PCRST = 8'h04,
                          S_MAR = 8'h08, S_MDR = 8'h10, S_WEN = 8'h20,
                          S_IR = 8'h40, S_OUT = 8'h80;

   // Hold a source for L cycles, then strobe the sinks in the cycle the value
   // is on bus_data.
   task automatic bus_move(input logic [2:0] sel, input logic [15:0] data, input logic [7:0] s);
      bus_sel_in = sel;
      ctrl_data  = data;
      repeat (L) tick();
      bus_sel_in = 3'd0;
      strobes(s);
      tick();
      strobes(8'h00);
   endtask

   initial begin
      // Reset
      reset = 1'b1;
      tick(); tick();
      check("reset bus_data", bus_data, 16'h0000);
      check("reset inst_reg", inst_reg, 16'h0000);
      check("reset out_reg",  out_reg,  16'h0000);
      check("reset pc",       {8'h00, pc}, 16'h0000);
      reset  = 1'b0;
      chk_on = 1'b1;

      // Latency: value appears exactly in the 4th cycle
      bus_sel_in = BUS_SEL_CTRL; ctrl_data = 16'hA5C3;
      tick(); check("latency c1", bus_data, 16'h0000);
      tick(); check("latency c2", bus_data, 16'h0000);
      tick(); check("latency c3", bus_data, 16'hA5C3);
      bus_sel_in = 3'd0;
      tick();

      // Fill RAM so every later read is of known data
      for (int a = 0; a < 256; a++) begin
         bus_move(BUS_SEL_CTRL, 16'(a), S_MAR);
         bus_move(BUS_SEL_CTRL, 16'(a * 16'h0101) ^ 16'h5A5A, S_MDR);
         mem_wen = 1'b1; tick(); mem_wen = 1'b0;
      end

      // RAM write/read through the bus
      bus_move(BUS_SEL_CTRL, 16'h0007, S_MAR);
      bus_move(BUS_SEL_CTRL, 16'h1234, S_MDR);
      mem_wen = 1'b1; tick(); mem_wen = 1'b0;
      tick();
      bus_move(BUS_SEL_MEM, 16'h0000, S_OUT);
      check("ram readback", out_reg, 16'h1234);

      // PC wrap and priority
      pc_reset = 1'b1; tick(); pc_reset = 1'b0;
      pc_increment = 1'b1;
      repeat (255) tick();
      check("pc at FF", {8'h00, pc}, 16'h00FF);
      tick();
      pc_increment = 1'b0;
      check("pc wrap", {8'h00, pc}, 16'h0000);
      bus_move(BUS_SEL_CTRL, 16'h0040, S_PCLD | S_PCINC);
      check("pc load over inc", {8'h00, pc}, 16'h0040);
      bus_move(BUS_SEL_PC, 16'h0000, S_OUT);
      check("pc on bus", out_reg, 16'h0040);
      bus_move(BUS_SEL_CTRL, 16'h0033, S_PCLD | S_PCRST);
      check("pc reset over load", {8'h00, pc}, 16'h0000);

      // Same-cycle MAR load + write uses the old MAR (07)
      bus_move(BUS_SEL_CTRL, 16'hBEEF, S_MDR);
      bus_move(BUS_SEL_CTRL, 16'h0009, S_MAR | S_WEN);
      tick();
      bus_move(BUS_SEL_MEM, 16'h0000, S_OUT);
      check("write at new MAR 09 untouched", out_reg, 16'h0909 ^ 16'h5A5A);
      bus_move(BUS_SEL_CTRL, 16'h0007, S_MAR);
      tick();
      bus_move(BUS_SEL_MEM, 16'h0000, S_OUT);
      check("write at old MAR 07", out_reg, 16'hBEEF);

      // ALU path and invalid select
      alu_result = 16'h00FF;
      bus_move(BUS_SEL_ALU, 16'h0000, S_OUT);
      check("alu to out", out_reg, 16'h00FF);
      bus_sel_in = 3'd6;
      repeat (L) tick();
      check("sel 6 bus", bus_data, 16'h0000);
      bus_sel_in = 3'd0;

      // Reset mid-transfer
      bus_move(BUS_SEL_CTRL, 16'h0077, S_PCLD);
      bus_move(BUS_SEL_CTRL, 16'hC0DE, S_IR);
      bus_move(BUS_SEL_CTRL, 16'h0020, S_MAR);
      mac_result = 16'hABCD;
      bus_sel_in = BUS_SEL_MAC;
      tick(); tick();
      reset = 1'b1;
      tick();
      check("midreset bus", bus_data, 16'h0000);
      check("midreset ir",  inst_reg, 16'h0000);
      check("midreset out", out_reg,  16'h0000);
      check("midreset pc",  {8'h00, pc}, 16'h0000);
      reset = 1'b0; bus_sel_in = 3'd0;
      tick();
      bus_move(BUS_SEL_MEM, 16'h0000, S_OUT);
      check("ram kept, MAR=0", out_reg, 16'h5A5A);

      // Randomized phase
      for (int c = 0; c < 3000; c++) begin
         bus_sel_in   = 3'($urandom_range(0, 7));
         ctrl_data    = 16'($urandom);
         alu_result   = 16'($urandom);
         mac_result   = 16'($urandom);
         pc_reset     = ($urandom_range(0, 15) == 0);
         pc_load      = ($urandom_range(0, 5) == 0);
         pc_increment = ($urandom_range(0, 2) == 0);
         addr_reg_en  = ($urandom_range(0, 3) == 0);
         data_reg_en  = ($urandom_range(0, 3) == 0);
         mem_wen      = ($urandom_range(0, 3) == 0);
         inst_reg_en  = ($urandom_range(0, 3) == 0);
         out_reg_en   = ($urandom_range(0, 3) == 0);
         reset        = ($urandom_range(0, 149) == 0);
         tick();
      end
      reset = 1'b0;
      bus_sel_in = 3'd0;
      strobes(8'h00);
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_sap1_bus_datapath
`default_nettype wire
